// File: rtl/sop_pkg.sv
// Shared types and default sizing for the truth-table extractor and its emitter.
package sop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_W,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  localparam int unsigned SOP_N = 4;
  localparam int unsigned TT_W  = 2 ** SOP_N;
  localparam int unsigned CNT_W = SOP_N + 1;

endpackage

// File: rtl/sop_minterm_emitter.sv
// Walks a recovered truth table and streams set-bit indices in ascending order
// over a registered valid/ready slice; one index per cycle, zeros skipped.
module sop_minterm_emitter
  import sop_pkg::*;
#(
  parameter  int unsigned N       = SOP_N,
  localparam int unsigned TT_BITS = 1 << N,
  localparam int unsigned P_BITS  = N + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [TT_BITS-1:0] table_i,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [N-1:0]       m_idx,
  output logic               fin
);

  logic [P_BITS-1:0] p_q, p_d;
  logic              m_valid_q, m_valid_d;
  logic [N-1:0]      m_idx_q, m_idx_d;
  logic              found;
  logic [N-1:0]      hit;
  logic              take;

  // Lowest set bit at or above the search pointer; descending loop so the lowest wins.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    for (int unsigned i = TT_BITS; i > 0; i--) begin
      if (table_i[i-1] && ((i - 1) >= 32'(p_q))) begin
        found = 1'b1;
        hit   = N'(i - 1);
      end
    end
  end

  assign take = !m_valid_q || m_ready;

  always_comb begin
    p_d       = p_q;
    m_valid_d = m_valid_q;
    m_idx_d   = m_idx_q;
    if (!en) begin
      p_d       = '0;
      m_valid_d = 1'b0;
    end else if (take) begin
      if (found) begin
        m_valid_d = 1'b1;
        m_idx_d   = hit;
        p_d       = P_BITS'(hit) + P_BITS'(1);
      end else begin
        m_valid_d = 1'b0;
        p_d       = P_BITS'(TT_BITS);
      end
    end
  end

  assign fin = en && take && !found;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      m_valid_q <= 1'b0;
      m_idx_q   <= '0;
    end else begin
      p_q       <= p_d;
      m_valid_q <= m_valid_d;
      m_idx_q   <= m_idx_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_idx   = m_idx_q;

endmodule

// File: rtl/sop_truth_table_extractor.sv
// Scans every input combination of an external N-input function, rebuilds its
// truth table and minterm count, then streams the minterm indices out.
module sop_truth_table_extractor
  import sop_pkg::*;
#(
  parameter  int unsigned N        = SOP_N,
  parameter  int unsigned SETTLE   = 1,
  localparam int unsigned TT_BITS  = 1 << N,
  localparam int unsigned CNT_BITS = N + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N-1:0]        stim,
  input  logic                f_in,
  output logic                busy,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N-1:0]        m_idx,
  output logic [TT_BITS-1:0]  table_q,
  output logic [CNT_BITS-1:0] count,
  output logic                done
);

  // With no settle time the scan alternates SAMPLE only, giving one cycle per index.
  localparam state_t     SCAN_NEXT   = (SETTLE == 0) ? SAMPLE : SETTLE_W;
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t                state_q, state_d;
  logic [N-1:0]          idx_q, idx_d;
  logic [3:0]            settle_q, settle_d;
  logic [TT_BITS-1:0]    table_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  emit_fin;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    table_d  = table_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = '0;
          settle_d = '0;
          table_d  = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SCAN_NEXT;
        end
      end
      SETTLE_W: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = f_in;
        cnt_d          = cnt_q + CNT_BITS'(f_in);
        if (idx_q == '1) begin
          state_d = EMIT;
        end else begin
          idx_d   = idx_q + N'(1);
          state_d = SCAN_NEXT;
        end
      end
      EMIT: begin
        if (emit_fin) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sop_minterm_emitter #(.N(N)) u_emitter (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == EMIT),
    .table_i (table_q),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_idx   (m_idx),
    .fin     (emit_fin)
  );

  assign stim  = idx_q;
  assign busy  = busy_q;
  assign count = cnt_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sop_truth_table_extractor.sv
// Scoreboard bench: a truth-table model drives f_in, expected minterms are queued
// at start and popped by an independent monitor on each accepted transfer.
module tb_sop_truth_table_extractor;
  import sop_pkg::*;

  localparam int unsigned N = SOP_N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             m_ready = 1'b1;
  logic             f_in;
  logic [N-1:0]     stim, m_idx;
  logic             busy, m_valid, done;
  logic [TT_W-1:0]  table_q;
  logic [CNT_W-1:0] count;

  logic             start0 = 1'b0;
  logic             m_ready0 = 1'b1;
  logic             f_in0;
  logic [N-1:0]     stim0, m_idx0;
  logic             busy0, m_valid0, done0;
  logic [TT_W-1:0]  table_q0;
  logic [CNT_W-1:0] count0;

  logic [TT_W-1:0]  tt_cur = '0;

  assign f_in  = tt_cur[stim];
  assign f_in0 = tt_cur[stim0];

  sop_truth_table_extractor #(.N(N), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .f_in(f_in), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .table_q(table_q),
    .count(count), .done(done)
  );

  sop_truth_table_extractor #(.N(N), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stim(stim0), .f_in(f_in0), .busy(busy0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_idx(m_idx0), .table_q(table_q0),
    .count(count0), .done(done0)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, cyc_start = 0, first_valid = -1, done_cnt = 0, xfer_cnt = 0, done_rel = 0;
  int ready_mode = 0, stall_left = 0;
  bit stalled12 = 1'b0;
  int unsigned exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [TT_W-1:0] sop_table();
    logic [TT_W-1:0] t;
    logic [3:0] s;
    logic i1, i2, i3, i4;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      {i1, i2, i3, i4} = s;
      t[k] = (i1 & i2) | (i2 & ~i3 & i4) | (~i1 & ~i2 & i3 & i4);
    end
    return t;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every accepted transfer and checks stall stability.
  initial begin
    logic prev_stall;
    logic [N-1:0] prev_idx;
    prev_stall = 1'b0;
    prev_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", 32'({m_valid, m_idx}), 32'({1'b1, prev_idx}));
        if (m_valid && first_valid < 0) first_valid = cyc - cyc_start;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("extra_transfer", 32'(exp_q.size()), 32'd1);
          else chk("m_idx", 32'(m_idx), 32'(exp_q.pop_front()));
          xfer_cnt++;
        end
        if (done) done_cnt++;
        prev_stall = m_valid && !m_ready;
        prev_idx = m_idx;
      end
    end
  end

  // Consumer: always ready, toggling (with one 5-cycle stall on index 12), or random.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      m_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 1 && m_valid && m_idx == 4'd12 && !stalled12) begin
      stalled12 = 1'b1;
      stall_left = 4;
      m_ready = 1'b0;
    end else begin
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_stim"}, 32'(stim), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_idx"}, 32'(m_idx), 32'd0);
    chk({tag, "_table"}, 32'(table_q), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_scan();
    for (int k = 0; k < int'(TT_W); k++) if (tt_cur[k]) exp_q.push_back(k);
    first_valid = -1;
    done_cnt = 0;
    xfer_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc_start = cyc;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_scan(input string tag, input logic [TT_W-1:0] exp_tt, input int exp_first);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 400);
    done_rel = cyc - cyc_start;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_table"}, 32'(table_q), 32'(exp_tt));
    chk({tag, "_count"}, 32'(count), 32'($countones(exp_tt)));
    chk({tag, "_first_valid"}, 32'(first_valid), 32'(exp_first));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_table_hold"}, 32'(table_q), 32'(exp_tt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int first0, nvalid0, s0;
    int unsigned q0[$];

    tt_cur = sop_table();
    do_reset("rst_init");

    ready_mode = 0;
    start_scan();
    finish_scan("sop", 16'hF028, 33);
    chk("sop_done_cycle", 32'(done_rel), 32'd39);
    chk("stim_hold", 32'(stim), 32'd15);

    ready_mode = 1;
    stalled12 = 1'b0;
    start_scan();
    finish_scan("sop_bp", 16'hF028, 33);

    ready_mode = 2;
    tt_cur = '0;
    start_scan();
    finish_scan("zero", 16'h0000, -1);
    chk("zero_done_cycle", 32'(done_rel), 32'd33);
    tt_cur = '1;
    start_scan();
    finish_scan("ones", 16'hFFFF, 33);

    tt_cur = sop_table();
    ready_mode = 0;
    start_scan();
    repeat (9) @(posedge clk);
    #1;
    do_reset("rst_scan");
    start_scan();
    c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (xfer_cnt < 2 && c < 200);
    #1;
    chk("emit_reached", 32'(xfer_cnt), 32'd2);
    do_reset("rst_emit");
    start_scan();
    finish_scan("after_rst", 16'hF028, 33);

    start_scan();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!m_valid && c < 100);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_scan("ign_start", 16'hF028, 33);

    for (int r = 0; r < 4; r++) begin
      tt_cur = TT_W'($urandom);
      ready_mode = 2;
      start_scan();
      finish_scan("rand", tt_cur, (tt_cur != '0) ? 33 : -1);
    end

    tt_cur = sop_table();
    for (int k = 0; k < int'(TT_W); k++) if (tt_cur[k]) q0.push_back(k);
    first0 = -1;
    nvalid0 = 0;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    s0 = cyc;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (m_valid0) begin
        if (first0 < 0) first0 = cyc - s0;
        nvalid0++;
        if (q0.size() > 0) chk("s0_m_idx", 32'(m_idx0), 32'(q0.pop_front()));
      end
    end while (!done0 && c < 200);
    chk("s0_done_seen", 32'(done0), 32'd1);
    chk("s0_first_valid", 32'(first0), 32'd17);
    chk("s0_nvalid", 32'(nvalid0), 32'd6);
    chk("s0_table", 32'(table_q0), 32'h0000F028);
    chk("s0_count", 32'(count0), 32'd6);
    @(posedge clk);
    @(negedge clk);
    chk("s0_busy_low", 32'(busy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sop_truth_table_extractor.md
Name: sop_truth_table_extractor

Overview:
- Sequential inverse of the 4-input sum-of-products network: drives every input combination into an external combinational function, samples its output, and rebuilds the truth table.
- Streams the recovered minterm indices out over a valid/ready handshake.
- Used as an on-chip checker beside the combinational SoP/PoS gate blocks, e.g. for the 4-input SoP instance.

Parameters:
- N, 4, number of function inputs; supported range 2..6.
- SETTLE, 1, wait cycles after each stimulus change before sampling; range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a scan; honoured only in IDLE.
- stim  output  N  stimulus to the function under test; stim[N-1] drives i1 (MSB) and stim[0] drives the last input.
- f_in  input  1  output of the function under test (o1).
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- m_valid  output  1  a minterm index is presented on m_idx.
- m_ready  input  1  consumer accepts m_idx when m_valid && m_ready.
- m_idx  output  N  minterm index, emitted in ascending order.
- table_q  output  2^N  recovered truth table; bit k = f(k).
- count  output  N+1  number of minterms (popcount of table_q).
- done  output  1  one-cycle pulse after the last minterm is accepted, or at the end of the scan if there are no minterms.

Behaviour:
- Reset values: state IDLE; stim 0, busy 0, m_valid 0, m_idx 0, table_q 0, count 0, done 0; internal index and settle counters 0. Reset wins over every other event, including mid-scan and mid-emit. A reset during EMIT drops m_valid in the following cycle with no further transfer.
- IDLE: a start pulse loads idx=0, stim=0, clears table_q and count, and moves to SETTLE_W. A start pulse in any other state is ignored.
- SETTLE_W: holds stim=idx. Stays for SETTLE cycles, then goes to SAMPLE. With SETTLE=0 it goes to SAMPLE in the next cycle.
- SAMPLE: table_q[idx] <= f_in, and count increments when f_in=1.
  - If idx = 2^N-1, go to EMIT with the scan pointer reset to 0.
  - Otherwise idx++, stim updates in the same edge, and go to SETTLE_W.
  - Scan length is 2^N*(SETTLE+1) cycles from the start edge to the EMIT entry; this is 32 cycles for the defaults.
- EMIT: the pointer p walks 0..2^N-1 at one index per cycle, skipping zeros.
  - m_valid=1 with m_idx=p only where table_q[p]=1.
  - m_idx and m_valid are registered outputs and stay stable while m_valid && !m_ready (no drop, no change).
  - After the transfer of the highest minterm, go to DONE. If count=0, go straight to DONE without ever asserting m_valid.
- DONE: done=1 for exactly one cycle, busy falls, then IDLE. table_q and count hold until the next accepted start.
- stim holds its last value (2^N-1) after the scan.
- Width rules: count is N+1 bits so that the all-ones function (count=2^N) does not wrap. The idx counter stops at 2^N-1 and never wraps.

Decomposition:
- Shared package (sop_pkg): the state enum (IDLE, SETTLE_W, SAMPLE, EMIT, DONE) and localparams TT_W=2**N and CNT_W=N+1.
- One sub-module: sop_minterm_emitter. It holds the p pointer, the skip-zero search and the valid/ready register slice, with table_q as its input.
- The scan FSM and counters stay in the top-level module.

Test Plan:
- DUT = the 4-input SoP (i1&i2 | i2&~i3&i4 | ~i1&~i2&i3&i4), SETTLE=1, m_ready=1: start -> table_q=16'hF028, count=6, m_idx sequence 3,5,12,13,14,15 on consecutive valid cycles, done once, first m_valid 33 cycles after start.
- Same DUT with m_ready toggled 0/1 every cycle and held low 5 cycles on idx 12 -> identical sequence, m_idx stable while stalled, no duplicates or losses.
- f_in tied 0 -> table_q=0, count=0, m_valid never high, done 1 cycle after scan end; f_in tied 1 -> count=16 (5'b10000), indices 0..15.
- rst asserted at scan cycle 10, then mid-EMIT after 2 transfers -> all outputs at reset values the next cycle; a fresh start gives a full correct result.
- start pulsed during SETTLE_W and EMIT -> ignored, no restart, and the result matches the single-start run; SETTLE=0 run -> the scan takes 16 cycles with the same table.
